risc_eunit_pipe: RTL and testbench
==================================

// Module: risc_eunit_pipe
// PURPOSE
//  Parametrised execution unit for the lab RISC datapath: sits between decode and data-memory/writeback.
//  - Adds a valid/ready handshake on both sides and a registered carry/zero/negative flag register.
//  - Adds carry-chained ADC/SBC ops and a multi-cycle shift-add MUL.
//  - Opcode field widens to 5 bits; codes 0x00-0x0F keep the existing ISA meaning.
// PARAMETERS
//  DW  8  data/operand width (>=4)
//  AW  4  data-memory address width
//  RW  3  destination register address width
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst         in   1   synchronous reset, active-high
//  in_vld      in   1   decode presents an op this cycle
//  in_rdy      out  1   unit accepts op (transfer when in_vld & in_rdy)
//  opcode      in   5   0x00 NOP,01 ADD,02 SUB,03 AND,04 OR,05 XOR,06 INC,07 DEC,08 NOT,09 NEG,0A SHR,0B SHL,0C ROR,0D ROL,0E LD,0F ST,10 ADC,11 SBC,12 MUL; others illegal
//  oprnd_a     in   DW  operand A
//  oprnd_b     in   DW  operand B
//  dstin       in   RW  destination register
//  dmaddrin    in   AW  memory address from decode
//  out_vld     out  1   result stage holds a valid op
//  out_rdy     in   1   downstream consumes (transfer when out_vld & out_rdy)
//  rslt        out  DW  registered result; dmdatain = rslt
//  dmdatain    out  DW  store data
//  dst_o       out  RW  registered destination
//  dmaddr_o    out  AW  registered memory address
//  dmenbl      out  1   out_vld & (LD|ST)
//  rdwr        out  1   0 only when out_vld & ST, else 1
//  load_op     out  1   out_vld & LD
//  reg_wr_vld  out  1   out_vld & op not in {NOP,ST,illegal}
//  flags       out  3   {C,Z,N}, registered
//  busy        out  1   MUL iteration in progress
// BEHAVIOUR
//  - Reset (rst=1 at edge): out_vld=0, rslt=0, dst_o=0, dmaddr_o=0, flags=0, busy=0, MUL state IDLE; in-flight MUL discarded, nothing emitted.
//  - in_rdy = ~busy & (~out_vld | out_rdy); combinational, no in_vld->in_rdy path.
//  - Single-cycle ops: accepted at edge N -> rslt/ctrl/out_vld valid after edge N; held stable while out_vld & ~out_rdy.
//  - Arithmetic on DW+1-bit adder:
//    ADD a+b; SUB a+~b+1; INC a+1; DEC a+~1+1; NEG ~a+1.
//    ADC a+b+C; SBC a+~b+C (C=1 means no borrow).
//    C = adder carry out.
//  - Logic/shift: NOT is bitwise ~a. SHR/SHL fill 0. ROR/ROL rotate by 1. LD/ST pass oprnd_a.
//  - NOP and illegal opcodes: rslt=0, out_vld still asserts; no writes.
//  - Flags update only when an op is written into the result stage:
//    arith ops (ADD..NEG, ADC, SBC) write C,Z,N; logic/shift/MUL write Z,N and keep C.
//    NOP/LD/ST/illegal keep all flags.
//    ADC/SBC issued back-to-back see the flags of the immediately preceding op (internal forward, no bubble).
//  - MUL FSM IDLE->RUN->DONE:
//    accept: acc=0, mcand=a, mplier=b, cnt=DW, busy=1.
//    RUN, each cycle: if mplier[0] acc+=mcand; mcand<<=1; mplier>>=1; cnt-=1; at cnt==1 go DONE.
//    DONE: rslt=acc[DW-1:0], out_vld=1, busy=0 -> IDLE.
//    Latency DW+1 cycles accept->out_vld; in_rdy low throughout.
//    A MUL is accepted only when the output stage is free (in_rdy rule); result stage is empty while busy.
//  - Simultaneous out-transfer and in-accept: new op replaces old in the same edge, no bubble.
// CONFIGURATION
//  RISC_EUNIT_MUL_EN defined: MUL (0x12) implemented as above.
//  Not defined: 0x12 is illegal (single-cycle, rslt=0, reg_wr_vld=0); busy tied 0; FSM and MUL registers absent.
// TESTING (DW=8)
//  1. Reset: rst held 2 cycles -> all outputs 0, rdwr=1, in_rdy=1; rst pulsed during MUL RUN -> busy=0, no out_vld.
//  2. ADD 0xFF+0x01 then ADC 0x00+0x00 back-to-back, out_rdy=1 -> rslt 0x00 flags C1Z1N0, then rslt 0x01 flags C0Z0N0.
//  3. SUB 0x05-0x07 -> rslt 0xFE, C=0, N=1; NOT 0x0F -> 0xF0; ROL 0x81 -> 0x03; ROR 0x01 -> 0x80.
//  4. Backpressure: out_rdy=0 with ST a=0x5A addr=0x3 -> rslt 0x5A, dmenbl=1, rdwr=0 held; in_rdy=0 until out_rdy=1.
//  5. MUL 0x0D*0x0B (MUL_EN) -> in_rdy low 9 cycles, rslt 0x8F, Z0N1, C unchanged; without MUL_EN -> rslt 0, reg_wr_vld=0.
//  6. LD a=0x22 dst=5 -> load_op=1, dmenbl=1, reg_wr_vld=1, dst_o=5; NOP -> reg_wr_vld=0, flags unchanged.

Source files
------------

// File: rtl/risc_eunit_pipe.sv
// Execution unit with valid/ready handshake, {C,Z,N} flag register and carry-chained ADC/SBC.
// Define RISC_EUNIT_MUL_EN to build the multi-cycle shift-add MUL (opcode 0x12).
module risc_eunit_pipe #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4,
    parameter int unsigned RW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [4:0]    opcode,
    input  logic [DW-1:0] oprnd_a,
    input  logic [DW-1:0] oprnd_b,
    input  logic [RW-1:0] dstin,
    input  logic [AW-1:0] dmaddrin,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] rslt,
    output logic [DW-1:0] dmdatain,
    output logic [RW-1:0] dst_o,
    output logic [AW-1:0] dmaddr_o,
    output logic          dmenbl,
    output logic          rdwr,
    output logic          load_op,
    output logic          reg_wr_vld,
    output logic [2:0]    flags,
    output logic          busy
);

    localparam logic [4:0] OP_NOP = 5'h00, OP_ADD = 5'h01, OP_SUB = 5'h02, OP_AND = 5'h03;
    localparam logic [4:0] OP_OR  = 5'h04, OP_XOR = 5'h05, OP_INC = 5'h06, OP_DEC = 5'h07;
    localparam logic [4:0] OP_NOT = 5'h08, OP_NEG = 5'h09, OP_SHR = 5'h0A, OP_SHL = 5'h0B;
    localparam logic [4:0] OP_ROR = 5'h0C, OP_ROL = 5'h0D, OP_LD  = 5'h0E, OP_ST  = 5'h0F;
    localparam logic [4:0] OP_ADC = 5'h10, OP_SBC = 5'h11;

    logic          accept_c;
    logic          is_mul_c;
    logic          op_legal;
    logic [4:0]    op_q;
    logic [DW-1:0] add_x, add_y;
    logic          add_ci;
    logic [DW:0]   sum_c;
    logic [DW-1:0] res_c;
    logic [2:0]    flags_c;
    logic          upd_zn;

`ifdef RISC_EUNIT_MUL_EN
    localparam logic [4:0]  OP_MUL = 5'h12;
    localparam int unsigned CW     = $clog2(DW + 1);
    typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_t;
    mul_state_t    mul_state;
    logic [DW-1:0] acc, mcand, mplier;
    logic [CW-1:0] cnt;

    assign is_mul_c = (opcode == OP_MUL);
    assign busy     = (mul_state != MUL_IDLE);
    assign op_legal = (op_q <= OP_MUL);
`else
    assign is_mul_c = 1'b0;
    assign busy     = 1'b0;
    assign op_legal = (op_q <= OP_SBC);
`endif

    assign in_rdy     = ~busy & (~out_vld | out_rdy);
    assign accept_c   = in_vld & in_rdy;
    assign dmdatain   = rslt;
    assign dmenbl     = out_vld & ((op_q == OP_LD) | (op_q == OP_ST));
    assign load_op    = out_vld & (op_q == OP_LD);
    assign rdwr       = ~(out_vld & (op_q == OP_ST));
    assign reg_wr_vld = out_vld & op_legal & (op_q != OP_NOP) & (op_q != OP_ST);

    // Shared DW+1-bit adder; carry-in comes from the live C flag for ADC/SBC.
    always_comb begin
        add_x  = oprnd_a;
        add_y  = '0;
        add_ci = 1'b0;
        case (opcode)
            OP_ADD: add_y = oprnd_b;
            OP_SUB: begin add_y = ~oprnd_b; add_ci = 1'b1; end
            OP_INC: add_ci = 1'b1;
            OP_DEC: begin add_y = ~(DW'(1)); add_ci = 1'b1; end
            OP_NEG: begin add_x = ~oprnd_a; add_ci = 1'b1; end
            OP_ADC: begin add_y = oprnd_b; add_ci = flags[2]; end
            OP_SBC: begin add_y = ~oprnd_b; add_ci = flags[2]; end
            default: ;
        endcase
        sum_c = {1'b0, add_x} + {1'b0, add_y} + (DW+1)'(add_ci);
    end

    always_comb begin
        res_c   = '0;
        flags_c = flags;
        upd_zn  = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_NEG, OP_ADC, OP_SBC: begin
                res_c      = sum_c[DW-1:0];
                flags_c[2] = sum_c[DW];
                upd_zn     = 1'b1;
            end
            OP_AND: begin res_c = oprnd_a & oprnd_b; upd_zn = 1'b1; end
            OP_OR:  begin res_c = oprnd_a | oprnd_b; upd_zn = 1'b1; end
            OP_XOR: begin res_c = oprnd_a ^ oprnd_b; upd_zn = 1'b1; end
            OP_NOT: begin res_c = ~oprnd_a; upd_zn = 1'b1; end
            OP_SHR: begin res_c = {1'b0, oprnd_a[DW-1:1]}; upd_zn = 1'b1; end
            OP_SHL: begin res_c = {oprnd_a[DW-2:0], 1'b0}; upd_zn = 1'b1; end
            OP_ROR: begin res_c = {oprnd_a[0], oprnd_a[DW-1:1]}; upd_zn = 1'b1; end
            OP_ROL: begin res_c = {oprnd_a[DW-2:0], oprnd_a[DW-1]}; upd_zn = 1'b1; end
            OP_LD, OP_ST: res_c = oprnd_a;
            default: ;
        endcase
        if (upd_zn) begin
            flags_c[1] = (res_c == '0);
            flags_c[0] = res_c[DW-1];
        end
    end

    // Result stage, flag register and MUL sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld   <= 1'b0;
            rslt      <= '0;
            dst_o     <= '0;
            dmaddr_o  <= '0;
            op_q      <= OP_NOP;
            flags     <= '0;
`ifdef RISC_EUNIT_MUL_EN
            mul_state <= MUL_IDLE;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
`endif
        end else begin
            if (accept_c) begin
                // A MUL parks its control fields here; the stage stays invalid until DONE.
                out_vld  <= ~is_mul_c;
                dst_o    <= dstin;
                dmaddr_o <= dmaddrin;
                op_q     <= opcode;
                if (!is_mul_c) begin
                    rslt  <= res_c;
                    flags <= flags_c;
                end
            end
`ifdef RISC_EUNIT_MUL_EN
            else if (mul_state == MUL_DONE) begin
                out_vld <= 1'b1;
                rslt    <= acc;
                flags   <= {flags[2], (acc == '0), acc[DW-1]};
            end
`endif
            else if (out_rdy) begin
                out_vld <= 1'b0;
            end
`ifdef RISC_EUNIT_MUL_EN
            case (mul_state)
                MUL_IDLE: begin
                    if (accept_c && is_mul_c) begin
                        acc       <= '0;
                        mcand     <= oprnd_a;
                        mplier    <= oprnd_b;
                        cnt       <= CW'(DW);
                        mul_state <= MUL_RUN;
                    end
                end
                MUL_RUN: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= {mcand[DW-2:0], 1'b0};
                    mplier <= {1'b0, mplier[DW-1:1]};
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) mul_state <= MUL_DONE;
                end
                MUL_DONE: mul_state <= MUL_IDLE;
                default:  mul_state <= MUL_IDLE;
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_risc_eunit_pipe.sv
// Directed self-checking bench for risc_eunit_pipe (DW=8), covering both MUL build options.
module tb_risc_eunit_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_vld;
    logic       in_rdy;
    logic [4:0] opcode;
    logic [7:0] oprnd_a, oprnd_b;
    logic [2:0] dstin;
    logic [3:0] dmaddrin;
    logic       out_vld;
    logic       out_rdy;
    logic [7:0] rslt, dmdatain;
    logic [2:0] dst_o;
    logic [3:0] dmaddr_o;
    logic       dmenbl, rdwr, load_op, reg_wr_vld;
    logic [2:0] flags;
    logic       busy;

    int n_chk  = 0;
    int n_pass = 0;

    risc_eunit_pipe #(.DW(8), .AW(4), .RW(3)) dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .opcode(opcode),
        .oprnd_a(oprnd_a), .oprnd_b(oprnd_b), .dstin(dstin), .dmaddrin(dmaddrin),
        .out_vld(out_vld), .out_rdy(out_rdy), .rslt(rslt), .dmdatain(dmdatain),
        .dst_o(dst_o), .dmaddr_o(dmaddr_o), .dmenbl(dmenbl), .rdwr(rdwr),
        .load_op(load_op), .reg_wr_vld(reg_wr_vld), .flags(flags), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] d, input logic [3:0] ad);
        opcode = op; oprnd_a = a; oprnd_b = b; dstin = d; dmaddrin = ad;
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic [7:0] r, input logic [2:0] f);
        check({tag, "_vld"}, 32'(out_vld), 1);
        check({tag, "_rslt"}, 32'(rslt), 32'(r));
        check({tag, "_flags"}, 32'(flags), 32'(f));
    endtask

    initial begin
        int low;
        int hits;
        bit got;
        rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b1;
        opcode = 5'h00; oprnd_a = 8'h00; oprnd_b = 8'h00; dstin = 3'd0; dmaddrin = 4'd0;
        tick(); tick();
        check("rst_vld", 32'(out_vld), 0);
        check("rst_rslt", 32'(rslt), 0);
        check("rst_dst", 32'(dst_o), 0);
        check("rst_addr", 32'(dmaddr_o), 0);
        check("rst_flags", 32'(flags), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rdwr", 32'(rdwr), 1);
        check("rst_inrdy", 32'(in_rdy), 1);
        check("rst_dmen", 32'(dmenbl), 0);
        check("rst_regwr", 32'(reg_wr_vld), 0);
        rst = 1'b0;

        // ADD then ADC back-to-back: ADC must see the carry ADD just produced.
        issue(5'h01, 8'hFF, 8'h01, 3'd1, 4'd0);
        expect_res("add", 8'h00, 3'b110);
        issue(5'h10, 8'h00, 8'h00, 3'd1, 4'd0);
        expect_res("adc", 8'h01, 3'b000);

        issue(5'h02, 8'h05, 8'h07, 3'd2, 4'd0);
        expect_res("sub", 8'hFE, 3'b001);
        check("sub_regwr", 32'(reg_wr_vld), 1);
        issue(5'h08, 8'h0F, 8'h00, 3'd2, 4'd0);
        expect_res("not", 8'hF0, 3'b001);
        issue(5'h0D, 8'h81, 8'h00, 3'd2, 4'd0);
        expect_res("rol", 8'h03, 3'b000);
        issue(5'h0C, 8'h01, 8'h00, 3'd2, 4'd0);
        expect_res("ror", 8'h80, 3'b001);

        // Backpressure with a store held in the result stage.
        tick();
        check("drain_vld", 32'(out_vld), 0);
        out_rdy = 1'b0;
        issue(5'h0F, 8'h5A, 8'h00, 3'd2, 4'h3);
        expect_res("st", 8'h5A, 3'b001);
        check("st_dmen", 32'(dmenbl), 1);
        check("st_rdwr", 32'(rdwr), 0);
        check("st_addr", 32'(dmaddr_o), 3);
        check("st_data", 32'(dmdatain), 32'h5A);
        check("st_regwr", 32'(reg_wr_vld), 0);
        opcode = 5'h01; oprnd_a = 8'h01; oprnd_b = 8'h01; dstin = 3'd3; in_vld = 1'b1;
        tick(); tick();
        check("hold_rslt", 32'(rslt), 32'h5A);
        check("hold_rdwr", 32'(rdwr), 0);
        check("hold_inrdy", 32'(in_rdy), 0);
        check("hold_vld", 32'(out_vld), 1);
        out_rdy = 1'b1;
        #1;
        check("rel_inrdy", 32'(in_rdy), 1);
        tick();
        in_vld = 1'b0;
        expect_res("swap_add", 8'h02, 3'b000);
        check("swap_rdwr", 32'(rdwr), 1);
        check("swap_dst", 32'(dst_o), 3);

        // MUL with C=1 going in.
        issue(5'h01, 8'hFF, 8'h01, 3'd1, 4'd0);
        expect_res("pre_mul", 8'h00, 3'b110);
        issue(5'h12, 8'h0D, 8'h0B, 3'd4, 4'd0);
`ifdef RISC_EUNIT_MUL_EN
        low = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (out_vld) got = 1'b1;
            else begin
                if (!in_rdy) low++;
                tick();
            end
        end
        check("mul_done", 32'(got), 1);
        check("mul_lat", 32'(low), 9);
        expect_res("mul", 8'h8F, 3'b101);
        check("mul_busy", 32'(busy), 0);
        check("mul_regwr", 32'(reg_wr_vld), 1);
        check("mul_dst", 32'(dst_o), 4);
`else
        expect_res("mul_ill", 8'h00, 3'b110);
        check("mul_ill_regwr", 32'(reg_wr_vld), 0);
        check("mul_ill_busy", 32'(busy), 0);
`endif

        // Reset while a MUL is in flight: nothing may emerge afterwards.
        tick();
        issue(5'h12, 8'h0D, 8'h0B, 3'd4, 4'd0);
        tick(); tick();
        rst = 1'b1;
        tick();
        check("rstmul_busy", 32'(busy), 0);
        check("rstmul_vld", 32'(out_vld), 0);
        rst = 1'b0;
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_vld) hits++;
        end
        check("rstmul_noout", 32'(hits), 0);
        check("rstmul_flags", 32'(flags), 0);

        issue(5'h0E, 8'h22, 8'h00, 3'd5, 4'h7);
        expect_res("ld", 8'h22, 3'b000);
        check("ld_loadop", 32'(load_op), 1);
        check("ld_dmen", 32'(dmenbl), 1);
        check("ld_regwr", 32'(reg_wr_vld), 1);
        check("ld_dst", 32'(dst_o), 5);
        check("ld_rdwr", 32'(rdwr), 1);
        issue(5'h02, 8'h05, 8'h07, 3'd1, 4'd0);
        expect_res("sub2", 8'hFE, 3'b001);
        issue(5'h11, 8'h05, 8'h03, 3'd1, 4'd0);
        expect_res("sbc_borrow", 8'h01, 3'b100);
        issue(5'h00, 8'h33, 8'h44, 3'd1, 4'd0);
        expect_res("nop", 8'h00, 3'b100);
        check("nop_regwr", 32'(reg_wr_vld), 0);
        issue(5'h1F, 8'h33, 8'h44, 3'd1, 4'd0);
        expect_res("illegal", 8'h00, 3'b100);
        check("illegal_regwr", 32'(reg_wr_vld), 0);
        issue(5'h06, 8'hFF, 8'h00, 3'd1, 4'd0);
        expect_res("inc", 8'h00, 3'b110);
        issue(5'h07, 8'h00, 8'h00, 3'd1, 4'd0);
        expect_res("dec", 8'hFF, 3'b001);
        issue(5'h09, 8'h01, 8'h00, 3'd1, 4'd0);
        expect_res("neg", 8'hFF, 3'b001);
        issue(5'h0A, 8'h81, 8'h00, 3'd1, 4'd0);
        expect_res("shr", 8'h40, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
